hazard_unit: RTL and testbench

Pipeline hazard and stall controller for the 5-stage RISC-V core. It consumes the control fields leaving ID/EX, EX/MEM and MEM/WB, and drives the write-enable and flush inputs of the PC and all pipeline registers. It also drives the EX-stage forwarding selects and runs the req/ack handshake with the data memory, freezing the pipeline until each MEM-stage access completes.

---
 rtl/core_pkg.sv | 16 +
 rtl/forward_unit.sv | 30 +++
 rtl/hazard_unit.sv | 159 +++++++++++++++
 tb/tb_hazard_unit.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types for the hazard/forwarding slice of the 5-stage core.
// Forward selects and the memory-handshake FSM state encoding.
package core_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } hz_state_t;

endpackage

// File: rtl/forward_unit.sv
// EX operand bypass select for one source register.
// MEM result beats WB result; x0 is never bypassed.
module forward_unit
  import core_pkg::*;
(
  input  logic [4:0] i_rs,
  input  logic [4:0] i_wr_mem,
  input  logic       i_rw_mem,
  input  logic [4:0] i_wr_wb,
  input  logic       i_rw_wb,
  output fwd_sel_t   o_sel
);

  logic w_hit_mem;
  logic w_hit_wb;

  assign w_hit_mem = i_rw_mem && (i_wr_mem != 5'd0)
                     && (i_wr_mem == i_rs);
  assign w_hit_wb  = i_rw_wb && (i_wr_wb != 5'd0)
                     && (i_wr_wb == i_rs);

  always_comb begin
    o_sel = FWD_RF;
    if (w_hit_mem)
      o_sel = FWD_MEM;
    else if (w_hit_wb)
      o_sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline stall/flush controller, dmem req/ack freeze FSM,
// forwarding selects and saturating stall/flush counters.
module hazard_unit
  import core_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             uses_rs1_ID,
  input  logic             uses_rs2_ID,
  input  logic [4:0]       rs1_EX,
  input  logic [4:0]       rs2_EX,
  input  logic [4:0]       wrin_EX,
  input  logic             MemRead_EX,
  input  logic             branch_taken_EX,
  input  logic [4:0]       wrin_MEM,
  input  logic             RegWrite_MEM,
  input  logic             mem_access_MEM,
  input  logic [4:0]       wrin_WB,
  input  logic             RegWrite_WB,
  input  logic             dmem_ack,
  output logic             PCWrite,
  output logic             IFID_Write,
  output logic             IDEX_Write,
  output logic             EXMEM_Write,
  output logic             MEMWB_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic             dmem_req,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WCW = $clog2(TIMEOUT + 1);

  hz_state_t        r_state;
  hz_state_t        w_next;
  logic [WCW-1:0]   r_wait_cnt;
  logic             r_timeout;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_wait;
  logic             w_tmo_hit;
  logic             w_freeze;
  logic             w_lu;
  logic             w_sel_br;
  logic             w_sel_lu;
  fwd_sel_t         w_fwd_a;
  fwd_sel_t         w_fwd_b;

  forward_unit u_fwd_a (
    .i_rs     (rs1_EX),
    .i_wr_mem (wrin_MEM),
    .i_rw_mem (RegWrite_MEM),
    .i_wr_wb  (wrin_WB),
    .i_rw_wb  (RegWrite_WB),
    .o_sel    (w_fwd_a)
  );

  forward_unit u_fwd_b (
    .i_rs     (rs2_EX),
    .i_wr_mem (wrin_MEM),
    .i_rw_mem (RegWrite_MEM),
    .i_wr_wb  (wrin_WB),
    .i_rw_wb  (RegWrite_WB),
    .o_sel    (w_fwd_b)
  );

  assign ForwardA = w_fwd_a;
  assign ForwardB = w_fwd_b;

  assign w_wait    = (r_state == WAIT);
  assign w_tmo_hit = w_wait
                     && (r_wait_cnt == WCW'(TIMEOUT - 1));
  assign w_freeze  = (!w_wait && mem_access_MEM)
                     || (w_wait && !dmem_ack && !w_tmo_hit);

  assign w_lu = MemRead_EX && (wrin_EX != 5'd0)
                && ((uses_rs1_ID && (rs1_ID == wrin_EX))
                 || (uses_rs2_ID && (rs2_ID == wrin_EX)));

  // A branch held in EX during a freeze flushes on the release cycle
  assign w_sel_br = !w_freeze && branch_taken_EX;
  assign w_sel_lu = !w_freeze && !branch_taken_EX && w_lu;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)
      r_state <= RUN;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      RUN:  if (mem_access_MEM) w_next = WAIT;
      WAIT: if (dmem_ack || w_tmo_hit) w_next = RUN;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b1;
    IFID_Write  = 1'b1;
    IDEX_Write  = 1'b1;
    EXMEM_Write = 1'b1;
    MEMWB_Write = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Flush  = 1'b0;
    unique case (1'b1)
      w_freeze: begin
        PCWrite     = 1'b0;
        IFID_Write  = 1'b0;
        IDEX_Write  = 1'b0;
        EXMEM_Write = 1'b0;
        MEMWB_Write = 1'b0;
      end
      w_sel_br: begin
        IFID_Flush = 1'b1;
        IDEX_Flush = 1'b1;
      end
      w_sel_lu: begin
        PCWrite    = 1'b0;
        IFID_Write = 1'b0;
        IDEX_Flush = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_wait_cnt  <= '0;
      r_timeout   <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_wait_cnt <= w_wait ? r_wait_cnt + 1'b1 : '0;
      if (w_tmo_hit)
        r_timeout <= 1'b1;
      if (!PCWrite && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_sel_br && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign dmem_req    = w_wait;
  assign mem_timeout = r_timeout;
  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_hazard_unit.sv
// Scenario bench for hazard_unit: scoreboarded per-cycle
// control vectors plus counter and sticky-timeout checks.
module tb_hazard_unit;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic [4:0] rs1_ID = '0, rs2_ID = '0;
  logic       uses_rs1_ID = 0, uses_rs2_ID = 0;
  logic [4:0] rs1_EX = '0, rs2_EX = '0, wrin_EX = '0;
  logic       MemRead_EX = 0, branch_taken_EX = 0;
  logic [4:0] wrin_MEM = '0, wrin_WB = '0;
  logic       RegWrite_MEM = 0, mem_access_MEM = 0;
  logic       RegWrite_WB = 0, dmem_ack = 0;
  logic       PCWrite, IFID_Write, IDEX_Write;
  logic       EXMEM_Write, MEMWB_Write;
  logic       IFID_Flush, IDEX_Flush;
  logic [1:0] ForwardA, ForwardB;
  logic       dmem_req, mem_timeout;
  logic [3:0] stall_cnt, flush_cnt;

  always #5 CLK = ~CLK;

  hazard_unit #(.TIMEOUT(8), .CNT_W(4)) dut (
    .CLK             (CLK),
    .RESET_N         (RESET_N),
    .rs1_ID          (rs1_ID),
    .rs2_ID          (rs2_ID),
    .uses_rs1_ID     (uses_rs1_ID),
    .uses_rs2_ID     (uses_rs2_ID),
    .rs1_EX          (rs1_EX),
    .rs2_EX          (rs2_EX),
    .wrin_EX         (wrin_EX),
    .MemRead_EX      (MemRead_EX),
    .branch_taken_EX (branch_taken_EX),
    .wrin_MEM        (wrin_MEM),
    .RegWrite_MEM    (RegWrite_MEM),
    .mem_access_MEM  (mem_access_MEM),
    .wrin_WB         (wrin_WB),
    .RegWrite_WB     (RegWrite_WB),
    .dmem_ack        (dmem_ack),
    .PCWrite         (PCWrite),
    .IFID_Write      (IFID_Write),
    .IDEX_Write      (IDEX_Write),
    .EXMEM_Write     (EXMEM_Write),
    .MEMWB_Write     (MEMWB_Write),
    .IFID_Flush      (IFID_Flush),
    .IDEX_Flush      (IDEX_Flush),
    .ForwardA        (ForwardA),
    .ForwardB        (ForwardB),
    .dmem_req        (dmem_req),
    .mem_timeout     (mem_timeout),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  typedef struct packed {
    logic [4:0] rs1i, rs2i;
    logic       u1, u2;
    logic [4:0] rs1e, rs2e, wex;
    logic       mr, br;
    logic [4:0] wmem;
    logic       rwm, acc;
    logic [4:0] wwb;
    logic       rwb, ack;
  } stim_t;

  // {PC,IFID,IDEX,EXMEM,MEMWB enables, IFID/IDEX flush}
  localparam logic [6:0] E_RUN = 7'b1111100;
  localparam logic [6:0] E_FRZ = 7'b0000000;
  localparam logic [6:0] E_LU  = 7'b0011101;
  localparam logic [6:0] E_BR  = 7'b1111111;

  logic [12:0] sb[$];
  int vec = 0;
  int miss = 0;

  function automatic logic [12:0] obs();
    return {PCWrite, IFID_Write, IDEX_Write, EXMEM_Write,
            MEMWB_Write, IFID_Flush, IDEX_Flush,
            ForwardA, ForwardB, dmem_req, mem_timeout};
  endfunction

  task automatic drive(input stim_t s);
    rs1_ID = s.rs1i; rs2_ID = s.rs2i;
    uses_rs1_ID = s.u1; uses_rs2_ID = s.u2;
    rs1_EX = s.rs1e; rs2_EX = s.rs2e;
    wrin_EX = s.wex; MemRead_EX = s.mr;
    branch_taken_EX = s.br;
    wrin_MEM = s.wmem; RegWrite_MEM = s.rwm;
    mem_access_MEM = s.acc;
    wrin_WB = s.wwb; RegWrite_WB = s.rwb;
    dmem_ack = s.ack;
  endtask

  // Drive one cycle after the falling edge and queue its expectation
  task automatic cyc(input stim_t s, input logic [12:0] e);
    @(negedge CLK);
    drive(s);
    sb.push_back(e);
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    drive('0);
    RESET_N = 1'b0;
    #2;
    RESET_N = 1'b1;
    sb.delete();
  endtask

  task automatic test_reset();
    logic [12:0] e;
    drive('0);
    RESET_N = 1'b0;
    #1;
    sb.push_back({E_RUN, 2'b00, 2'b00, 1'b0, 1'b0});
    e = sb.pop_front();
    vec++;
    if (obs() !== e) begin
      $display("FAIL reset_ctl got=%b exp=%b", obs(), e);
      miss++;
    end
    vec++;
    if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
      $display("FAIL reset_cnt got=%0d/%0d exp=0/0",
               stall_cnt, flush_cnt);
      miss++;
    end
    #3;
    RESET_N = 1'b1;
  endtask

  task automatic test_load_use();
    stim_t s;
    logic [12:0] e, x;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      s = '0;
      e = {E_RUN, 6'b0};
      case (c)
        0: begin s.mr = 1; s.wex = 5; s.rs1i = 5; s.u1 = 1;
                 e = {E_LU, 6'b0}; end
        2: begin s.mr = 1; s.wex = 0; s.rs1i = 0; s.u1 = 1; end
        3: begin s.mr = 1; s.wex = 9; s.rs2i = 9; s.u2 = 1;
                 e = {E_LU, 6'b0}; end
        4: begin s.mr = 1; s.wex = 9; s.rs1i = 9; end
        5: begin s.wex = 9; s.rs1i = 9; s.u1 = 1; end
        default: ;
      endcase
      cyc(s, e);
      x = sb.pop_front();
      vec++;
      if (obs() !== x) begin
        $display("FAIL load_use c%0d got=%b exp=%b", c, obs(), x);
        miss++;
      end
      if (c == 1 || c == 6) begin
        vec++;
        if (stall_cnt !== ((c == 1) ? 4'd1 : 4'd2)) begin
          $display("FAIL lu_stall_cnt c%0d got=%0d exp=%0d",
                   c, stall_cnt, (c == 1) ? 1 : 2);
          miss++;
        end
      end
    end
  endtask

  task automatic test_forward();
    stim_t s;
    logic [12:0] e, x;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      s = '0;
      e = {E_RUN, 6'b0};
      case (c)
        0: begin s.rwm = 1; s.rwb = 1; s.wmem = 7; s.wwb = 7;
                 s.rs1e = 7; e[5:4] = 2'b10; end
        1: begin s.rwb = 1; s.wmem = 7; s.wwb = 7;
                 s.rs1e = 7; e[5:4] = 2'b01; end
        2: begin s.rwm = 1; s.wmem = 0; s.rwb = 1; s.wwb = 0; end
        3: begin s.rwm = 1; s.wmem = 12; s.rwb = 1; s.wwb = 12;
                 s.rs1e = 12; s.rs2e = 12; e[5:2] = 4'b1010; end
        4: begin s.rwb = 1; s.wwb = 4; s.rs1e = 4; s.rwm = 1;
                 s.wmem = 6; s.rs2e = 5; e[5:4] = 2'b01; end
        default: ;
      endcase
      cyc(s, e);
      x = sb.pop_front();
      vec++;
      if (obs() !== x) begin
        $display("FAIL forward c%0d got=%b exp=%b", c, obs(), x);
        miss++;
      end
    end
  endtask

  task automatic test_branch();
    stim_t s;
    logic [12:0] e, x;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      s = '0;
      e = {E_RUN, 6'b0};
      case (c)
        0: begin s.br = 1; s.mr = 1; s.wex = 5; s.rs1i = 5;
                 s.u1 = 1; e = {E_BR, 6'b0}; end
        2: begin s.acc = 1; s.br = 1; e = {E_FRZ, 6'b0}; end
        3: begin s.acc = 1; s.br = 1; s.ack = 1;
                 e = {E_BR, 4'b0, 1'b1, 1'b0}; end
        default: ;
      endcase
      cyc(s, e);
      x = sb.pop_front();
      vec++;
      if (obs() !== x) begin
        $display("FAIL branch c%0d got=%b exp=%b", c, obs(), x);
        miss++;
      end
      if (c == 1 || c == 4) begin
        vec++;
        if (flush_cnt !== ((c == 1) ? 4'd1 : 4'd2)
            || stall_cnt !== ((c == 1) ? 4'd0 : 4'd1)) begin
          $display("FAIL branch_cnt c%0d got=%0d/%0d", c,
                   flush_cnt, stall_cnt);
          miss++;
        end
      end
    end
  endtask

  task automatic test_handshake();
    stim_t s;
    logic [12:0] e, x;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      s = '0;
      s.acc = (c < 5);
      s.ack = (c == 4);
      if (c == 0)      e = {E_FRZ, 6'b0};
      else if (c < 4)  e = {E_FRZ, 4'b0, 1'b1, 1'b0};
      else if (c == 4) e = {E_RUN, 4'b0, 1'b1, 1'b0};
      else             e = {E_RUN, 6'b0};
      cyc(s, e);
      x = sb.pop_front();
      vec++;
      if (obs() !== x) begin
        $display("FAIL handshake c%0d got=%b exp=%b", c, obs(), x);
        miss++;
      end
    end
    vec++;
    if (stall_cnt !== 4'd4) begin
      $display("FAIL hs_stall_cnt got=%0d exp=4", stall_cnt);
      miss++;
    end
  endtask

  task automatic test_back_to_back();
    stim_t s;
    logic [12:0] e, x;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      s = '0;
      s.acc = (c < 4);
      s.ack = (c < 2) || (c == 3);
      if (c == 0 || c == 2) e = {E_FRZ, 6'b0};
      else if (c == 4)      e = {E_RUN, 6'b0};
      else                  e = {E_RUN, 4'b0, 1'b1, 1'b0};
      cyc(s, e);
      x = sb.pop_front();
      vec++;
      if (obs() !== x) begin
        $display("FAIL b2b c%0d got=%b exp=%b", c, obs(), x);
        miss++;
      end
    end
    vec++;
    if (stall_cnt !== 4'd2) begin
      $display("FAIL b2b_stall_cnt got=%0d exp=2", stall_cnt);
      miss++;
    end
  endtask

  task automatic test_timeout();
    stim_t s;
    logic [12:0] e, x;
    do_reset();
    for (int c = 0; c < 13; c++) begin
      s = '0;
      s.acc = (c < 9) || (c == 10) || (c == 11);
      s.ack = (c == 11);
      if (c == 0)       e = {E_FRZ, 6'b0};
      else if (c < 8)   e = {E_FRZ, 4'b0, 2'b10};
      else if (c == 8)  e = {E_RUN, 4'b0, 2'b10};
      else if (c == 9)  e = {E_RUN, 4'b0, 2'b01};
      else if (c == 10) e = {E_FRZ, 4'b0, 2'b01};
      else if (c == 11) e = {E_RUN, 4'b0, 2'b11};
      else              e = {E_RUN, 4'b0, 2'b01};
      cyc(s, e);
      x = sb.pop_front();
      vec++;
      if (obs() !== x) begin
        $display("FAIL timeout c%0d got=%b exp=%b", c, obs(), x);
        miss++;
      end
    end
    vec++;
    if (stall_cnt !== 4'd9) begin
      $display("FAIL tmo_stall_cnt got=%0d exp=9", stall_cnt);
      miss++;
    end
  endtask

  task automatic test_saturate();
    stim_t s;
    do_reset();
    s = '0;
    s.mr = 1; s.wex = 3; s.rs2i = 3; s.u2 = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      drive(s);
    end
    @(negedge CLK);
    drive('0);
    #1;
    vec++;
    if (stall_cnt !== 4'hF) begin
      $display("FAIL stall_sat got=%0d exp=15", stall_cnt);
      miss++;
    end
  endtask

  task automatic test_reset_wait();
    stim_t s;
    logic [12:0] e, x;
    do_reset();
    s = '0;
    s.acc = 1;
    cyc(s, {E_FRZ, 6'b0});
    x = sb.pop_front();
    cyc(s, {E_FRZ, 4'b0, 2'b10});
    x = sb.pop_front();
    vec++;
    if (obs() !== x || stall_cnt !== 4'd1) begin
      $display("FAIL rst_wait_pre got=%b/%0d exp=%b/1",
               obs(), stall_cnt, x);
      miss++;
    end
    @(negedge CLK);
    #1;
    RESET_N = 1'b0;
    drive('0);
    #1;
    sb.push_back({E_RUN, 6'b0});
    e = sb.pop_front();
    vec++;
    if (obs() !== e || stall_cnt !== 4'd0 || flush_cnt !== 4'd0)
    begin
      $display("FAIL rst_wait got=%b/%0d/%0d exp=%b/0/0",
               obs(), stall_cnt, flush_cnt, e);
      miss++;
    end
    #2;
    RESET_N = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired vec=%0d", vec);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load_use();
    test_forward();
    test_branch();
    test_handshake();
    test_back_to_back();
    test_timeout();
    test_saturate();
    test_reset_wait();
    $display("== %0d vectors applied, %0d miscompares ==",
             vec, miss);
    $finish;
  end

endmodule
